program_loader: RTL and testbench
=================================

# program_loader

Front end of the instruction-memory load path. Accepts a byte stream from the debug/UART receiver after a start command and replays it as single-byte write pulses into the instruction memory's sequential write port, whose write pointer advances one byte per pulse. Reassembles big-endian 32-bit words on the fly to detect the halt instruction, which terminates the load. Flags programs that overflow memory capacity.

## Interface
- NB_BYTE, 8, width of one stream/memory byte
- NB_DATA, 32, instruction width
- N_INSTRUCTIONS, 32, instruction memory capacity in words
- NB_ADDRESS, 7, memory byte-address width; byte counter is NB_ADDRESS+1 bits
- HALT_WORD, 32'h40000000, halt instruction encoding

Ports:
- i_clock  in  1  single clock, all logic on posedge
- i_reset  in  1  synchronous, active-high; shared with instruction memory
- i_start  in  1  one-cycle load command
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  i_rx_data valid this cycle, one byte per asserted cycle, no backpressure
- o_write_data  out  NB_BYTE  byte to memory write port
- o_write_enable  out  1  one-cycle write pulse per forwarded byte
- o_byte_count  out  NB_ADDRESS+1  bytes written since start
- o_loading  out  1  state is LOAD (or CHECKSUM)
- o_load_done  out  1  sticky, halt received and load accepted
- o_load_error  out  1  sticky, capacity overflow (or checksum mismatch)

## Operation
- States: IDLE, LOAD, CHECKSUM (macro only), DONE, ERROR.
- IDLE: bytes ignored. i_start → LOAD; clears byte counter, word shift register, byte-in-word index.
- LOAD: each i_rx_valid byte is registered to o_write_data with o_write_enable=1, counter +1, and shifted into the word register. The first byte of a word lands in bits [31:24], matching the memory read order of addr+0..addr+3.
- Halt check only on word boundaries, when byte-in-word index wraps 3→0. If the assembled word == HALT_WORD → DONE (or CHECKSUM). The halt bytes themselves are written.
- Capacity: after byte N_INSTRUCTIONS*4 is written, if that word is not halt → ERROR. A halt in the final word → DONE.
- DONE/ERROR: sticky until i_reset. Bytes and i_start are ignored, no writes. Reload requires i_reset, since the memory's write pointer clears only on reset.
- i_start while in LOAD is ignored. i_start and i_rx_valid in the same cycle in IDLE: the byte is dropped.
- Reset mid-operation: state → IDLE, all outputs 0, in-flight byte discarded.

## Timing
- Reset value of every output: 0.
- Latency: i_rx_valid at cycle N → o_write_enable/o_write_data valid at cycle N+1, for exactly one cycle.
- Back-to-back valid bytes supported at full rate.
- o_byte_count updates in the same cycle as the corresponding write pulse.
- State change on the halt's 4th byte takes effect at the same edge. o_load_done rises in the same cycle as the final write pulse and o_loading falls then.
- Overflow: o_load_error rises with the 4*N_INSTRUCTIONS-th write pulse.
- i_start at cycle N → o_loading=1 at N+1.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined: after halt detection, enter CHECKSUM. The next valid byte is compared with the XOR of all written bytes. Match → DONE, mismatch → ERROR, one cycle after that byte. The checksum byte is never written, and o_loading stays high during CHECKSUM.
- Undefined: no CHECKSUM state; halt goes directly to DONE; no XOR logic.

## Structure
- Shared package: HALT_WORD, state encoding enum, N_BYTE_REGISTERS = N_INSTRUCTIONS*4, byte-counter width.
- One sub-module: byte_word_assembler, containing the shift register, 2-bit byte-in-word index, word-complete strobe and halt compare. The loader holds the FSM, counter, output registers and checksum.

## Test plan
- Start, then 16 back-to-back bytes (3 words + 40 00 00 00) → 16 pulses in order, one cycle after each valid; o_byte_count=16; o_load_done=1 with the 16th pulse.
- Same program with 2-cycle gaps between bytes → pulses track each valid with latency 1; no pulses in gaps.
- Bytes 00 40 00 00 00 … (halt pattern misaligned at offset 1) → no done; load continues.
- 128 non-halt bytes → 128 pulses, o_load_error=1 with the 128th; byte 129 produces no pulse. Variant with halt at bytes 124–127 → o_load_done=1, no error.
- i_reset after 6 bytes → all outputs 0 next cycle; later bytes without i_start produce no pulses; restart loads from count 0.
- Macro on: program + halt + correct XOR byte → done, byte not written; wrong XOR → o_load_error=1.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and sizes for the program loader.
// Optional checksum stage is enabled with PROGRAM_LOADER_CHECKSUM_EN.
package program_loader_pkg;

    localparam int NB_BYTE          = 8;
    localparam int NB_DATA          = 32;
    localparam int N_INSTRUCTIONS   = 32;
    localparam int NB_ADDRESS       = 7;
    localparam int NB_COUNT         = NB_ADDRESS + 1;
    localparam int N_BYTE_REGISTERS = N_INSTRUCTIONS * 4;

    localparam logic [NB_DATA-1:0] HALT_WORD = 32'h4000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECKSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/program_loader_byte_word_assembler.sv
// Rebuilds big-endian words from the byte stream and flags the halt word
// combinationally on the byte that completes it.
import program_loader_pkg::*;

module byte_word_assembler (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_word_done,
    output logic               o_halt
);

    // Only the three earlier bytes are stored; the fourth is the live input.
    logic [NB_DATA-NB_BYTE-1:0] shift_q;
    logic [1:0]                 idx_q;
    logic [NB_DATA-1:0]         word;

    assign word        = {shift_q, i_byte};
    assign o_word_done = i_shift && (idx_q == 2'd3);
    assign o_halt      = o_word_done && (word == HALT_WORD);

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (i_shift) begin
            shift_q <= {shift_q[NB_DATA-2*NB_BYTE-1:0], i_byte};
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Replays a received byte stream as memory write pulses until halt.
// PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
import program_loader_pkg::*;

module program_loader (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_write_data,
    output logic                o_write_enable,
    output logic [NB_COUNT-1:0] o_byte_count,
    output logic                o_loading,
    output logic                o_load_done,
    output logic                o_load_error
);

    state_e              state_q;
    logic [NB_BYTE-1:0]  data_q;
    logic                we_q;
    logic [NB_COUNT-1:0] count_q;
    logic [NB_COUNT-1:0] count_d;
    logic                loading_q;
    logic                done_q;
    logic                error_q;
    logic                shift_en;
    logic                clear;
    logic                word_done;
    logic                halt;
    logic                last_byte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [NB_BYTE-1:0]  xor_q;
`endif

    assign shift_en  = (state_q == ST_LOAD) && i_rx_valid;
    assign clear     = (state_q == ST_IDLE) && i_start;
    assign count_d   = count_q + NB_COUNT'(1);
    // Capacity always ends on a word boundary, so gate on the strobe.
    assign last_byte = word_done &&
                       (count_q == NB_COUNT'(N_BYTE_REGISTERS - 1));

    byte_word_assembler u_asm (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (clear),
        .i_shift     (shift_en),
        .i_byte      (i_rx_data),
        .o_word_done (word_done),
        .o_halt      (halt)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            we_q      <= 1'b0;
            count_q   <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q   <= ST_LOAD;
                        count_q   <= '0;
                        loading_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        xor_q     <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (i_rx_valid) begin
                        data_q  <= i_rx_data;
                        we_q    <= 1'b1;
                        count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        xor_q   <= xor_q ^ i_rx_data;
`endif
                        if (halt) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            state_q   <= ST_CHECKSUM;
`else
                            state_q   <= ST_DONE;
                            loading_q <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end else if (last_byte) begin
                            state_q   <= ST_ERROR;
                            loading_q <= 1'b0;
                            error_q   <= 1'b1;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHECKSUM: begin
                    if (i_rx_valid) begin
                        loading_q <= 1'b0;
                        if (i_rx_data == xor_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign o_write_data   = data_q;
    assign o_write_enable = we_q;
    assign o_byte_count   = count_q;
    assign o_loading      = loading_q;
    assign o_load_done    = done_q;
    assign o_load_error   = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: queued expected writes, negedge monitor.
module tb_program_loader;
    import program_loader_pkg::*;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic [7:0] o_write_data;
    logic       o_write_enable;
    logic [7:0] o_byte_count;
    logic       o_loading;
    logic       o_load_done;
    logic       o_load_error;

    always #5 clk = ~clk;

    program_loader dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_write_data   (o_write_data),
        .o_write_enable (o_write_enable),
        .o_byte_count   (o_byte_count),
        .o_loading      (o_loading),
        .o_load_done    (o_load_done),
        .o_load_error   (o_load_error)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
        int         cy;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_CKS  = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    int          m_st = M_IDLE;
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [31:0] m_word = '0;
    logic [7:0]  m_x = '0;

    logic [7:0] prog [16] = '{8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC,
                              8'h40, 8'h00, 8'h00, 8'h00};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_write_enable === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: data=%0h count=%0d cycle=%0d",
                         o_write_data, o_byte_count, cyc);
            end else begin
                mon_e = q.pop_front();
                if (o_write_data !== mon_e.d || o_byte_count !== mon_e.c ||
                    cyc != mon_e.cy) begin
                    failures++;
                    $display("FAIL write_pulse: got data=%0h count=%0d cycle=%0d, expected data=%0h count=%0d cycle=%0d",
                             o_write_data, o_byte_count, cyc,
                             mon_e.d, mon_e.c, mon_e.cy);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_cnt = 0;
        m_idx = 0;
        m_word = '0;
        m_x = '0;
        q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (m_st == M_LOAD) begin
            m_cnt++;
            e.d = b;
            e.c = 8'(m_cnt);
            e.cy = cyc + 1;
            q.push_back(e);
            m_x ^= b;
            m_word = {m_word[23:0], b};
            m_idx = (m_idx + 1) % 4;
            if (m_idx == 0 && m_word == 32'h4000_0000)
                m_st = CKS ? M_CKS : M_DONE;
            else if (m_cnt == 128)
                m_st = M_ERR;
        end else if (m_st == M_CKS) begin
            m_st = (b == m_x) ? M_DONE : M_ERR;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_rx_valid = 1'b0;
            i_start = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_start = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data = b;
        model_byte(b);
    endtask

    task automatic start_load();
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_start = 1'b1;
        if (m_st == M_IDLE) begin
            model_reset();
            m_st = M_LOAD;
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic reset_dut();
        idle(2);
        i_reset = 1'b1;
        model_reset();
        idle(2);
        i_reset = 1'b0;
    endtask

    initial begin
        // reset state
        reset_dut();
        chk("rst_we", o_write_enable, 0);
        chk("rst_data", o_write_data, 0);
        chk("rst_count", o_byte_count, 0);
        chk("rst_loading", o_loading, 0);
        chk("rst_done", o_load_done, 0);
        chk("rst_error", o_load_error, 0);

        // back-to-back program ending in halt
        start_load();
        chk("start_loading", o_loading, 1);
        chk("start_count", o_byte_count, 0);
        for (int i = 0; i < 16; i++) send(prog[i]);
        idle(1);
        chk("b2b_done", o_load_done, CKS ? 0 : 1);
        chk("b2b_loading", o_loading, CKS ? 1 : 0);
        chk("b2b_count", o_byte_count, 16);
        chk("b2b_error", o_load_error, 0);
        if (!CKS) begin
            send(8'h12);
            idle(2);
            chk("after_done_count", o_byte_count, 16);
            chk("after_done_sticky", o_load_done, 1);
        end
        idle(2);
        chk("b2b_queue_empty", q.size(), 0);

        // same program with two idle cycles between bytes
        reset_dut();
        start_load();
        for (int i = 0; i < 16; i++) begin
            send(prog[i]);
            idle(2);
        end
        chk("gap_done", o_load_done, CKS ? 0 : 1);
        chk("gap_count", o_byte_count, 16);
        chk("gap_queue_empty", q.size(), 0);

        // misaligned halt pattern, then ignored start in LOAD
        reset_dut();
        start_load();
        send(8'h00); send(8'h40); send(8'h00); send(8'h00);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        chk("mis_done", o_load_done, 0);
        chk("mis_loading", o_loading, 1);
        chk("mis_count", o_byte_count, 8);
        start_load();
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(1);
        chk("restart_ignored_count", o_byte_count, 12);
        chk("restart_ignored_loading", o_loading, 1);
        idle(2);
        chk("mis_queue_empty", q.size(), 0);

        // capacity overflow
        reset_dut();
        start_load();
        for (int i = 0; i < 127; i++) send(8'(i + 1));
        idle(1);
        chk("ovf_pre_error", o_load_error, 0);
        chk("ovf_pre_count", o_byte_count, 127);
        send(8'h80);
        idle(1);
        chk("ovf_error", o_load_error, 1);
        chk("ovf_count", o_byte_count, 128);
        chk("ovf_loading", o_loading, 0);
        chk("ovf_done", o_load_done, 0);
        send(8'h81);
        idle(2);
        chk("ovf_129_count", o_byte_count, 128);
        chk("ovf_129_we", o_write_enable, 0);
        chk("ovf_queue_empty", q.size(), 0);

        // halt in the final word
        reset_dut();
        start_load();
        for (int i = 0; i < 124; i++) send(8'(i + 1));
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        chk("last_word_done", o_load_done, CKS ? 0 : 1);
        chk("last_word_error", o_load_error, 0);
        chk("last_word_count", o_byte_count, 128);
        idle(2);
        chk("last_word_queue_empty", q.size(), 0);

        // reset mid-load with a byte in flight
        reset_dut();
        start_load();
        for (int i = 0; i < 6; i++) begin
            send(8'(8'hA0 + i));
            idle(1);
        end
        idle(1);
        @(negedge clk);
        i_reset = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data = 8'hEE;
        model_reset();
        @(negedge clk);
        i_reset = 1'b0;
        i_rx_valid = 1'b0;
        chk("midrst_we", o_write_enable, 0);
        chk("midrst_count", o_byte_count, 0);
        chk("midrst_loading", o_loading, 0);
        chk("midrst_data", o_write_data, 0);
        send(8'hAB); send(8'hCD); send(8'hEF);
        idle(2);
        chk("nostart_count", o_byte_count, 0);

        // start together with a valid byte drops that byte
        @(negedge clk);
        i_start = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data = 8'hC3;
        model_reset();
        m_st = M_LOAD;
        @(negedge clk);
        i_start = 1'b0;
        i_rx_valid = 1'b0;
        chk("start_drop_loading", o_loading, 1);
        chk("start_drop_count", o_byte_count, 0);
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
        idle(1);
        chk("reload_count", o_byte_count, 4);
        idle(2);
        chk("reload_queue_empty", q.size(), 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // checksum: 11^22^33^44^40 = 04
        reset_dut();
        start_load();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        idle(1);
        chk("cks_wait_loading", o_loading, 1);
        chk("cks_wait_done", o_load_done, 0);
        send(8'h04);
        idle(1);
        chk("cks_ok_done", o_load_done, 1);
        chk("cks_ok_error", o_load_error, 0);
        chk("cks_ok_loading", o_loading, 0);
        chk("cks_ok_count", o_byte_count, 8);
        reset_dut();
        start_load();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        send(8'h05);
        idle(1);
        chk("cks_bad_error", o_load_error, 1);
        chk("cks_bad_done", o_load_done, 0);
        idle(2);
        chk("cks_queue_empty", q.size(), 0);
`endif

        idle(2);
        chk("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
